// File: rtl/coherence_bus_ctrl.sv
// Memory-side coherence controller for two cores. Serialises icache and
// dcache requests onto one single-port RAM and runs a two-cycle snoop of
// the other dcache before coherence transactions, forwarding or writing
// back a dirty copy when the snooped cache holds one.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
);

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    WB,
    DACCESS,
    IACCESS
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_dptr;
  logic r_iptr;
  logic r_req;
  logic r_reqWrite;
  logic r_snoopCnt;

  logic w_nextDptr;
  logic w_nextIptr;
  logic w_nextReq;
  logic w_nextReqWrite;
  logic w_nextSnoopCnt;

  logic              w_oth;
  logic [CPUS-1:0]   w_dReq;
  logic              w_dGrant;
  logic              w_iGrant;
  logic [WORD_W-1:0] w_daddrReq;
  logic [WORD_W-1:0] w_dstoreReq;
  logic [WORD_W-1:0] w_dstoreOth;
  logic [WORD_W-1:0] w_iaddrReq;

  // The granted core and its partner, plus the words each state reads.
  assign w_oth       = ~r_req;
  assign w_dReq      = dREN | dWEN;
  assign w_dGrant    = w_dReq[r_dptr] ? r_dptr : ~r_dptr;
  assign w_iGrant    = iREN[r_iptr] ? r_iptr : ~r_iptr;
  assign w_daddrReq  = daddr[r_req*WORD_W +: WORD_W];
  assign w_dstoreReq = dstore[r_req*WORD_W +: WORD_W];
  assign w_dstoreOth = dstore[w_oth*WORD_W +: WORD_W];
  assign w_iaddrReq  = iaddr[r_req*WORD_W +: WORD_W];

  // State and arbitration registers; reset abandons any transaction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_dptr     <= 1'b0;
      r_iptr     <= 1'b0;
      r_req      <= 1'b0;
      r_reqWrite <= 1'b0;
      r_snoopCnt <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_dptr     <= w_nextDptr;
      r_iptr     <= w_nextIptr;
      r_req      <= w_nextReq;
      r_reqWrite <= w_nextReqWrite;
      r_snoopCnt <= w_nextSnoopCnt;
    end
  end

  // Next-state, grant bookkeeping and all bus/cache outputs.
  always_comb begin
    w_nextState    = r_state;
    w_nextDptr     = r_dptr;
    w_nextIptr     = r_iptr;
    w_nextReq      = r_req;
    w_nextReqWrite = r_reqWrite;
    w_nextSnoopCnt = r_snoopCnt;
    iwait          = '1;
    dwait          = '1;
    iload          = '0;
    dload          = '0;
    ccwait         = '0;
    ccinv          = '0;
    ccsnoopaddr    = '0;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;

    case (r_state)
      IDLE: begin
        if (|w_dReq) begin
          w_nextReq      = w_dGrant;
          w_nextReqWrite = dWEN[w_dGrant];
          w_nextDptr     = ~w_dGrant;
          w_nextSnoopCnt = 1'b0;
          w_nextState    = cctrans[w_dGrant] ? SNOOP : DACCESS;
        end else if (|iREN) begin
          w_nextReq   = w_iGrant;
          w_nextState = IACCESS;
        end
      end

      SNOOP: begin
        ccwait[w_oth] = 1'b1;
        ccinv[w_oth]  = ccwrite[r_req];
        ccsnoopaddr[w_oth*WORD_W +: WORD_W] = w_daddrReq;
        if (r_snoopCnt) begin
          w_nextSnoopCnt = 1'b0;
          w_nextState    = (ccwrite[w_oth] && dWEN[w_oth]) ? WB : DACCESS;
        end else begin
          w_nextSnoopCnt = 1'b1;
        end
      end

      WB: begin
        ccwait[w_oth] = 1'b1;
        ccinv[w_oth]  = ccwrite[r_req];
        ccsnoopaddr[w_oth*WORD_W +: WORD_W] = w_daddrReq;
        ramWEN   = 1'b1;
        ramaddr  = w_daddrReq;
        ramstore = w_dstoreOth;
        if (!ramwait) begin
          dwait[w_oth] = 1'b0;
          if (!r_reqWrite) begin
            dwait[r_req] = 1'b0;
            dload[r_req*WORD_W +: WORD_W] = w_dstoreOth;
            w_nextState = IDLE;
          end else begin
            w_nextState = DACCESS;
          end
        end
      end

      DACCESS: begin
        ramREN   = ~r_reqWrite;
        ramWEN   = r_reqWrite;
        ramaddr  = w_daddrReq;
        ramstore = w_dstoreReq;
        if (!ramwait) begin
          dwait[r_req] = 1'b0;
          dload[r_req*WORD_W +: WORD_W] = ramload;
          w_nextState = IDLE;
        end
      end

      IACCESS: begin
        ramREN  = 1'b1;
        ramaddr = w_iaddrReq;
        if (!ramwait) begin
          iwait[r_req] = 1'b0;
          iload[r_req*WORD_W +: WORD_W] = ramload;
          w_nextIptr  = ~r_req;
          w_nextState = IDLE;
        end
      end

      default: w_nextState = IDLE;
    endcase

    if (RST) begin
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: reset, plain read, snoops,
// dirty forward, invalidate, arbitration and reset mid-access.
module tb_coherence_bus_ctrl;

  logic        CLK;
  logic        RST;
  logic [1:0]  iREN;
  logic [63:0] iaddr;
  logic [1:0]  iwait;
  logic [63:0] iload;
  logic [1:0]  dREN;
  logic [1:0]  dWEN;
  logic [63:0] daddr;
  logic [63:0] dstore;
  logic [1:0]  dwait;
  logic [63:0] dload;
  logic [1:0]  cctrans;
  logic [1:0]  ccwrite;
  logic [1:0]  ccwait;
  logic [1:0]  ccinv;
  logic [63:0] ccsnoopaddr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramwait;

  int vectors;
  int miscompares;

  coherence_bus_ctrl #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // A core may never read and write in the same request.
  always @(posedge CLK) begin
    if (!RST) assert (!(|(dREN & dWEN))) else $error("[TB] dREN and dWEN both high on one core");
  end

  task automatic clearInputs;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; ramload = '0; ramwait = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    clearInputs();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    vectors++; if (dwait !== 2'b11) begin miscompares++; $display("FAIL reset_dwait: got %b expected 11", dwait); end
    vectors++; if (iwait !== 2'b11) begin miscompares++; $display("FAIL reset_iwait: got %b expected 11", iwait); end
    vectors++; if ({ramREN, ramWEN} !== 2'b00) begin miscompares++; $display("FAIL reset_ram: got %b expected 00", {ramREN, ramWEN}); end
    vectors++; if ({ccwait, ccinv} !== 4'b0000) begin miscompares++; $display("FAIL reset_cc: got %b expected 0000", {ccwait, ccinv}); end
    vectors++; if (ramaddr !== 32'h0) begin miscompares++; $display("FAIL reset_ramaddr: got %h expected 0", ramaddr); end
  endtask

  task automatic test_plain_read;
    @(negedge CLK);
    dREN = 2'b01; daddr[31:0] = 32'h100; ramwait = 1'b1;
    @(negedge CLK); #1;
    vectors++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin miscompares++; $display("FAIL read_strobe: got REN=%b addr=%h expected 1 00000100", ramREN, ramaddr); end
    vectors++; if (dwait !== 2'b11 || ccwait !== 2'b00) begin miscompares++; $display("FAIL read_stall: got dwait=%b ccwait=%b expected 11 00", dwait, ccwait); end
    @(negedge CLK);
    @(negedge CLK);
    ramwait = 1'b0; ramload = 32'hDEADBEEF;
    #1;
    vectors++; if (dwait !== 2'b10) begin miscompares++; $display("FAIL read_done: got %b expected 10", dwait); end
    vectors++; if (dload[31:0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_data: got %h expected deadbeef", dload[31:0]); end
    @(negedge CLK);
    clearInputs();
    #1;
    vectors++; if (dwait !== 2'b11) begin miscompares++; $display("FAIL read_single_pulse: got %b expected 11", dwait); end
  endtask

  task automatic test_snoop_clean;
    @(negedge CLK);
    dREN = 2'b10; cctrans = 2'b10; daddr[63:32] = 32'h200;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      vectors++; if (ccwait !== 2'b01 || ccinv !== 2'b00) begin miscompares++; $display("FAIL snoop_clean_cc%0d: got wait=%b inv=%b expected 01 00", k, ccwait, ccinv); end
      vectors++; if (ccsnoopaddr[31:0] !== 32'h200 || ramREN !== 1'b0) begin miscompares++; $display("FAIL snoop_clean_addr%0d: got %h REN=%b expected 00000200 0", k, ccsnoopaddr[31:0], ramREN); end
    end
    @(negedge CLK); #1;
    vectors++; if (ccwait !== 2'b00 || ramREN !== 1'b1 || ramaddr !== 32'h200) begin miscompares++; $display("FAIL snoop_clean_access: got cc=%b REN=%b addr=%h expected 00 1 00000200", ccwait, ramREN, ramaddr); end
    ramwait = 1'b0; ramload = 32'h12345678;
    #1;
    vectors++; if (dwait !== 2'b01 || dload[63:32] !== 32'h12345678) begin miscompares++; $display("FAIL snoop_clean_done: got %b %h expected 01 12345678", dwait, dload[63:32]); end
    @(negedge CLK);
    clearInputs();
  endtask

  task automatic test_snoop_dirty;
    @(negedge CLK);
    dREN = 2'b01; cctrans = 2'b01; daddr[31:0] = 32'h300;
    dWEN = 2'b10; ccwrite = 2'b10; dstore[63:32] = 32'hCAFE0001;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      vectors++; if (ccwait !== 2'b10 || ccinv !== 2'b00 || ccsnoopaddr[63:32] !== 32'h300) begin miscompares++; $display("FAIL snoop_dirty_cc%0d: got wait=%b inv=%b addr=%h expected 10 00 00000300", k, ccwait, ccinv, ccsnoopaddr[63:32]); end
    end
    @(negedge CLK); #1;
    vectors++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300 || ramstore !== 32'hCAFE0001) begin miscompares++; $display("FAIL dirty_wb: got WEN=%b addr=%h data=%h expected 1 00000300 cafe0001", ramWEN, ramaddr, ramstore); end
    vectors++; if (dwait !== 2'b11 || ccwait !== 2'b10) begin miscompares++; $display("FAIL dirty_wb_hold: got dwait=%b cc=%b expected 11 10", dwait, ccwait); end
    ramwait = 1'b0;
    #1;
    vectors++; if (dwait !== 2'b00) begin miscompares++; $display("FAIL dirty_both_done: got %b expected 00", dwait); end
    vectors++; if (dload[31:0] !== 32'hCAFE0001) begin miscompares++; $display("FAIL dirty_forward: got %h expected cafe0001", dload[31:0]); end
    @(negedge CLK);
    clearInputs();
    #1;
    vectors++; if (dwait !== 2'b11 || ramWEN !== 1'b0) begin miscompares++; $display("FAIL dirty_idle: got %b WEN=%b expected 11 0", dwait, ramWEN); end
  endtask

  task automatic test_invalidate;
    @(negedge CLK);
    dWEN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01;
    daddr[31:0] = 32'h400; dstore[31:0] = 32'hA5A50400;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      vectors++; if (ccinv !== 2'b10 || ccwait !== 2'b10 || ccsnoopaddr[63:32] !== 32'h400) begin miscompares++; $display("FAIL inval_cc%0d: got inv=%b wait=%b addr=%h expected 10 10 00000400", k, ccinv, ccwait, ccsnoopaddr[63:32]); end
    end
    @(negedge CLK); #1;
    vectors++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h400 || ramstore !== 32'hA5A50400) begin miscompares++; $display("FAIL inval_write: got WEN=%b REN=%b addr=%h data=%h expected 1 0 00000400 a5a50400", ramWEN, ramREN, ramaddr, ramstore); end
    vectors++; if (ccinv !== 2'b00) begin miscompares++; $display("FAIL inval_drop: got %b expected 00", ccinv); end
    ramwait = 1'b0;
    #1;
    vectors++; if (dwait !== 2'b10) begin miscompares++; $display("FAIL inval_done: got %b expected 10", dwait); end
    @(negedge CLK);
    clearInputs();
    #1;
    vectors++; if (dwait !== 2'b11) begin miscompares++; $display("FAIL inval_single_pulse: got %b expected 11", dwait); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  expWait;
    logic [31:0] expAddr;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    dREN = 2'b11; daddr = {32'h20, 32'h10};
    iREN = 2'b01; iaddr[31:0] = 32'h40;
    ramwait = 1'b0; ramload = 32'h0BADF00D;
    for (int k = 0; k < 6; k++) begin
      expWait = (k % 2 == 0) ? 2'b10 : 2'b01;
      expAddr = (k % 2 == 0) ? 32'h10 : 32'h20;
      @(negedge CLK); #1;
      vectors++; if (dwait !== expWait || ramaddr !== expAddr) begin miscompares++; $display("FAIL arb_grant%0d: got dwait=%b addr=%h expected %b %h", k, dwait, ramaddr, expWait, expAddr); end
      @(negedge CLK); #1;
      vectors++; if (dwait !== 2'b11 || iwait !== 2'b11) begin miscompares++; $display("FAIL arb_idle%0d: got dwait=%b iwait=%b expected 11 11", k, dwait, iwait); end
      if (k == 5) dREN = 2'b00;
    end
    @(negedge CLK); #1;
    vectors++; if (iwait !== 2'b10 || iload[31:0] !== 32'h0BADF00D || ramaddr !== 32'h40) begin miscompares++; $display("FAIL arb_icache: got iwait=%b iload=%h addr=%h expected 10 0badf00d 00000040", iwait, iload[31:0], ramaddr); end
    @(negedge CLK);
    clearInputs();
    #1;
    vectors++; if (iwait !== 2'b11) begin miscompares++; $display("FAIL arb_icache_pulse: got %b expected 11", iwait); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge CLK);
    dREN = 2'b10; daddr[63:32] = 32'h500; ramwait = 1'b1;
    @(negedge CLK); #1;
    vectors++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin miscompares++; $display("FAIL rst_mid_pre: got REN=%b addr=%h expected 1 00000500", ramREN, ramaddr); end
    RST = 1'b1;
    @(negedge CLK);
    ramwait = 1'b0;
    #1;
    vectors++; if (dwait !== 2'b11) begin miscompares++; $display("FAIL rst_mid_hold: got %b expected 11", dwait); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    vectors++; if (dwait !== 2'b11 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got dwait=%b REN=%b WEN=%b expected 11 0 0", dwait, ramREN, ramWEN); end
    dREN = 2'b00;
    @(negedge CLK); #1;
    vectors++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_pulse: got dwait=%b REN=%b expected 11 0", dwait, ramREN); end
    clearInputs();
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_plain_read();
    test_snoop_clean();
    test_snoop_dirty();
    test_invalidate();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
